datapath: RTL and testbench
===========================

Name: datapath

Overview:
- 32-bit single-bus CPU datapath. Holds R0–R15, HI, LO, Z (64-bit, as Zhigh/Zlow), PC, MDR, MAR, InPort, CSE, IR and Y, all sharing one 32-bit bus, plus an ALU.
- All sequencing comes from the external control unit (or a bench) as one-hot register in/out strobes and one-hot ALU operation strobes. There is no internal FSM.

Parameters:
- WIDTH, 32, data/bus/register width. The Z register is 2*WIDTH.

Ports:
- clock  input  1  rising-edge clock for all registers
- clear  input  1  asynchronous active-low reset; 0 clears all registers
- R0in..R15in  input  1 each  load Rn from the bus
- R0out..R15out  input  1 each  drive Rn onto the bus
- HIin, LOin, HIout, LOout  input  1 each  load/drive HI, LO
- Zhighin, Zlowin  input  1 each  load ALU result bits [63:32] / [31:0] into Z
- Zhighout, Zlowout  input  1 each  drive Z high/low word onto the bus
- PCin, PCout, MARin, MARout, IRin, IRout  input  1 each  load/drive PC, MAR, IR from/to the bus
- MDRin, MDRout  input  1 each  load MDR from the MDR mux / drive MDR onto the bus
- InPortin, InPortout, CSEin, CSEout  input  1 each  load/drive the InPort and CSE registers from/to the bus
- Mdatain  input  32  memory read data
- MDMuxread  input  1  MDR mux select: 1 selects Mdatain, 0 selects the bus
- Yin  input  1  load Y from the bus
- ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC  input  1 each  ALU operation strobes

Behaviour:
- Every register is WIDTH bits and loads on the rising clock edge when its *in strobe is 1; otherwise it holds.
- clear=0 asynchronously sets every register to 0, including Z. No outputs exist; all state is internal.
- Bus source is combinational. Priority when several *out strobes are high: R0 > … > R15 > HI > LO > Zhigh > Zlow > PC > MDR > MAR > InPort > CSE > IR. With no *out strobe high, the bus is 0.
- ALU operands: A = Y, B = bus. The 64-bit result C is combinational.
- Operation priority: IncPC > ADD > SUB > MUL > DIV > AND > OR > SHR > SHRA > SHL > ROR > ROL > NEG > NOT. With no strobe high, C = 0.
- IncPC: C[31:0] = B + 1.
- ADD, SUB: C[31:0] = A+B or A−B, mod 2^32.
- AND, OR: bitwise on A and B.
- NEG: C[31:0] = 0 − B. NOT: C[31:0] = ~B.
- Shifts operate on A by B[4:0]. SHR is logical, SHRA is arithmetic, SHL is logical left, ROR/ROL rotate.
- For all ops except MUL and DIV, C[63:32] = 0.
- MUL: C = signed A × signed B, full 64 bits.
- DIV: C[31:0] = signed A/B, truncated toward zero; C[63:32] = remainder, with the sign of A. If B = 0, C = 0.
- Zlowin captures C[31:0]; Zhighin captures C[63:32]. They may be asserted independently.
- A register may be read onto the bus and loaded in the same cycle; it takes the new value at the edge (e.g. Zlowout with PCin).
- MDR: loads Mdatain when MDMuxread=1, else the bus.
- Reset asserted mid-sequence clears state immediately. The first load after deassertion takes effect at the next rising edge.

Decomposition:
- Shared package: WIDTH constant, ALU op encoding (one-hot index constants), bus-source index constants.
- Sub-module datapath_alu (A, B, 14 op strobes → 64-bit C).
- Registers built from a generic reg32 instance or inline always blocks.

Test Plan:
- Reset: clear=0 mid-run → every register reads 0 via its *out strobe; Zlowout alone gives bus=0.
- Load path: Mdatain=0x12, MDMuxread=1, MDRin=1 for one edge; then MDRout with R2in → R2=0x00000012. Likewise R3=0xFFFFFFF2.
- SUB sequence: T0 PCout+IncPC+Zlowin (PC=0) → Zlow=1; T1 Zlowout+PCin, Mdatain=0x20918000 into MDR → PC=1; T2 MDRout+IRin → IR=0x20918000; T3 R2out+Yin; T4 R3out+SUB+Zlowin; T5 Zlowout+R1in → R1=0x00000020 (0x12 − 0xFFFFFFF2).
- MUL/DIV: Y=0xFFFFFFFA (−6), bus=7, MUL with Zhighin+Zlowin → Z=0xFFFFFFFF_FFFFFFD6. DIV −7/2 → Zlow=0xFFFFFFFD, Zhigh=0xFFFFFFFF. DIV by 0 → Z=0.
- Shifts/logic: Y=0x80000001, B=1 → SHR gives 0x40000000, SHRA 0xC0000000, SHL 0x00000002, ROR 0xC0000000, ROL 0x00000003. NEG on B=1 gives 0xFFFFFFFF; NOT on 0 gives 0xFFFFFFFF.
- Bus priority: R1out and R5out high together → bus = R1. No *out strobe high → Yin loads 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: word width, ALU strobe
// positions (lower index = higher priority) and bus source positions
// (lower index = higher bus priority).
package datapath_pkg;

   localparam int WIDTH = 32;

   localparam int NUM_OPS  = 14;
   localparam int OP_INCPC = 0;
   localparam int OP_ADD   = 1;
   localparam int OP_SUB   = 2;
   localparam int OP_MUL   = 3;
   localparam int OP_DIV   = 4;
   localparam int OP_AND   = 5;
   localparam int OP_OR    = 6;
   localparam int OP_SHR   = 7;
   localparam int OP_SHRA  = 8;
   localparam int OP_SHL   = 9;
   localparam int OP_ROR   = 10;
   localparam int OP_ROL   = 11;
   localparam int OP_NEG   = 12;
   localparam int OP_NOT   = 13;

   localparam int NUM_SRC    = 26;
   localparam int SRC_R0     = 0;
   localparam int SRC_HI     = 16;
   localparam int SRC_LO     = 17;
   localparam int SRC_ZHI    = 18;
   localparam int SRC_ZLO    = 19;
   localparam int SRC_PC     = 20;
   localparam int SRC_MDR    = 21;
   localparam int SRC_MAR    = 22;
   localparam int SRC_INPORT = 23;
   localparam int SRC_CSE    = 24;
   localparam int SRC_IR     = 25;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result, where
// only MUL and DIV populate the upper word.
module datapath_alu
   import datapath_pkg::*;
(
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [NUM_OPS-1:0] op,
   output logic [2*WIDTH-1:0] c
);

   logic [4:0]                sh;
   logic signed [2*WIDTH-1:0] a_ext;
   logic signed [2*WIDTH-1:0] b_ext;

   // Sign-extending to double width makes the product exact and keeps the
   // most-negative / -1 division from overflowing.
   assign sh    = b[4:0];
   assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

   // Priority-ordered operation select; no strobe yields zero.
   always_comb begin
      c = '0;
      if (op[OP_INCPC])     c[WIDTH-1:0] = b + WIDTH'(1);
      else if (op[OP_ADD])  c[WIDTH-1:0] = a + b;
      else if (op[OP_SUB])  c[WIDTH-1:0] = a - b;
      else if (op[OP_MUL])  c = a_ext * b_ext;
      else if (op[OP_DIV]) begin
         if (b != '0) c = {WIDTH'(a_ext % b_ext), WIDTH'(a_ext / b_ext)};
      end
      else if (op[OP_AND])  c[WIDTH-1:0] = a & b;
      else if (op[OP_OR])   c[WIDTH-1:0] = a | b;
      else if (op[OP_SHR])  c[WIDTH-1:0] = a >> sh;
      else if (op[OP_SHRA]) c[WIDTH-1:0] = WIDTH'(a_ext >>> sh);
      else if (op[OP_SHL])  c[WIDTH-1:0] = a << sh;
      else if (op[OP_ROR])  c[WIDTH-1:0] = WIDTH'({a, a} >> sh);
      else if (op[OP_ROL])  c[WIDTH-1:0] = WIDTH'(({a, a} << sh) >> WIDTH);
      else if (op[OP_NEG])  c[WIDTH-1:0] = -b;
      else if (op[OP_NOT])  c[WIDTH-1:0] = ~b;
   end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: register file, Y, 64-bit Z split into halves, MDR
// input mux and a priority bus driver. Sequencing is fully external.
module datapath
   import datapath_pkg::*;
(
   input  logic             clock,
   input  logic             clear,
   input  logic             R0in,  R1in,  R2in,  R3in,
   input  logic             R4in,  R5in,  R6in,  R7in,
   input  logic             R8in,  R9in,  R10in, R11in,
   input  logic             R12in, R13in, R14in, R15in,
   input  logic             R0out,  R1out,  R2out,  R3out,
   input  logic             R4out,  R5out,  R6out,  R7out,
   input  logic             R8out,  R9out,  R10out, R11out,
   input  logic             R12out, R13out, R14out, R15out,
   input  logic             HIin, LOin, HIout, LOout,
   input  logic             Zhighin, Zlowin, Zhighout, Zlowout,
   input  logic             PCin, PCout, MARin, MARout, IRin, IRout,
   input  logic             MDRin, MDRout,
   input  logic             InPortin, InPortout, CSEin, CSEout,
   input  logic [WIDTH-1:0] Mdatain,
   input  logic             MDMuxread,
   input  logic             Yin,
   input  logic             ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA,
   input  logic             SHL, ROR, ROL, NEG, NOT, IncPC
);

   logic [WIDTH-1:0]   bus;
   logic [WIDTH-1:0]   y;
   logic [WIDTH-1:0]   regs   [NUM_SRC];
   logic [WIDTH-1:0]   load_d [NUM_SRC];
   logic [NUM_SRC-1:0] in_sel;
   logic [NUM_SRC-1:0] out_sel;
   logic [NUM_OPS-1:0] op;
   logic [2*WIDTH-1:0] c;

   assign in_sel = {IRin, CSEin, InPortin, MARin, MDRin, PCin, Zlowin, Zhighin,
                    LOin, HIin,
                    R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

   assign out_sel = {IRout, CSEout, InPortout, MARout, MDRout, PCout, Zlowout, Zhighout,
                     LOout, HIout,
                     R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

   assign op = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV, MUL, SUB, ADD, IncPC};

   // Bus driver: scanning from the lowest priority up lets the highest win.
   always_comb begin
      bus = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (out_sel[i]) bus = regs[i];
      end
   end

   // Per-register load data: bus by default, ALU halves for Z, mux for MDR.
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) load_d[i] = bus;
      load_d[SRC_ZHI] = c[2*WIDTH-1:WIDTH];
      load_d[SRC_ZLO] = c[WIDTH-1:0];
      load_d[SRC_MDR] = MDMuxread ? Mdatain : bus;
   end

   // Bus-visible registers with individual load enables.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NUM_SRC; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (in_sel[i]) regs[i] <= load_d[i];
         end
      end
   end

   // Y holds the ALU A operand; it never drives the bus.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)   y <= '0;
      else if (Yin) y <= bus;
   end

   datapath_alu u_alu (
      .a  (y),
      .b  (bus),
      .op (op),
      .c  (c)
   );

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed micro-sequences plus randomized
// strobe traffic against a behavioural register/bus/ALU model.
`timescale 1ns/1ps
module tb_datapath;
   import datapath_pkg::*;

   logic               clock = 1'b0;
   logic               clear;
   logic [NUM_SRC-1:0] in_v;
   logic [NUM_SRC-1:0] out_v;
   logic [NUM_OPS-1:0] op_v;
   logic               yin;
   logic               md_mux;
   logic [31:0]        md;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_reg  [NUM_SRC];
   logic [31:0] m_y;
   logic [31:0] nx_reg [NUM_SRC];
   logic [31:0] nx_y;

   always #5 clock = ~clock;

   datapath dut (
      .clock(clock), .clear(clear),
      .R0in(in_v[0]),   .R1in(in_v[1]),   .R2in(in_v[2]),   .R3in(in_v[3]),
      .R4in(in_v[4]),   .R5in(in_v[5]),   .R6in(in_v[6]),   .R7in(in_v[7]),
      .R8in(in_v[8]),   .R9in(in_v[9]),   .R10in(in_v[10]), .R11in(in_v[11]),
      .R12in(in_v[12]), .R13in(in_v[13]), .R14in(in_v[14]), .R15in(in_v[15]),
      .R0out(out_v[0]),   .R1out(out_v[1]),   .R2out(out_v[2]),   .R3out(out_v[3]),
      .R4out(out_v[4]),   .R5out(out_v[5]),   .R6out(out_v[6]),   .R7out(out_v[7]),
      .R8out(out_v[8]),   .R9out(out_v[9]),   .R10out(out_v[10]), .R11out(out_v[11]),
      .R12out(out_v[12]), .R13out(out_v[13]), .R14out(out_v[14]), .R15out(out_v[15]),
      .HIin(in_v[SRC_HI]), .LOin(in_v[SRC_LO]), .HIout(out_v[SRC_HI]), .LOout(out_v[SRC_LO]),
      .Zhighin(in_v[SRC_ZHI]), .Zlowin(in_v[SRC_ZLO]),
      .Zhighout(out_v[SRC_ZHI]), .Zlowout(out_v[SRC_ZLO]),
      .PCin(in_v[SRC_PC]), .PCout(out_v[SRC_PC]),
      .MARin(in_v[SRC_MAR]), .MARout(out_v[SRC_MAR]),
      .IRin(in_v[SRC_IR]), .IRout(out_v[SRC_IR]),
      .MDRin(in_v[SRC_MDR]), .MDRout(out_v[SRC_MDR]),
      .InPortin(in_v[SRC_INPORT]), .InPortout(out_v[SRC_INPORT]),
      .CSEin(in_v[SRC_CSE]), .CSEout(out_v[SRC_CSE]),
      .Mdatain(md), .MDMuxread(md_mux), .Yin(yin),
      .ADD(op_v[OP_ADD]), .SUB(op_v[OP_SUB]), .MUL(op_v[OP_MUL]), .DIV(op_v[OP_DIV]),
      .AND(op_v[OP_AND]), .OR(op_v[OP_OR]), .SHR(op_v[OP_SHR]), .SHRA(op_v[OP_SHRA]),
      .SHL(op_v[OP_SHL]), .ROR(op_v[OP_ROR]), .ROL(op_v[OP_ROL]), .NEG(op_v[OP_NEG]),
      .NOT(op_v[OP_NOT]), .IncPC(op_v[OP_INCPC])
   );

   function automatic logic [NUM_SRC-1:0] sel(input int k);
      logic [NUM_SRC-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [NUM_OPS-1:0] opb(input int k);
      logic [NUM_OPS-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   // Reference bus: first source in priority order that is enabled.
   function automatic logic [31:0] ref_bus(input logic [NUM_SRC-1:0] o);
      for (int i = 0; i < NUM_SRC; i++) if (o[i]) return m_reg[i];
      return 32'h0;
   endfunction

   // Reference ALU using plain 64-bit integer arithmetic.
   function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [NUM_OPS-1:0] op);
      longint      sa, sb, t, q, rm;
      logic [31:0] r;
      int          k;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      k = -1;
      for (int i = NUM_OPS - 1; i >= 0; i--) if (op[i]) k = i;
      r = a;
      case (k)
         OP_INCPC: return {32'h0, b + 32'd1};
         OP_ADD:   return {32'h0, a + b};
         OP_SUB:   return {32'h0, a - b};
         OP_MUL:   begin t = sa * sb; return t; end
         OP_DIV: begin
            if (b == 32'h0) return 64'h0;
            q  = sa / sb;
            rm = sa % sb;
            return {rm[31:0], q[31:0]};
         end
         OP_AND:   return {32'h0, a & b};
         OP_OR:    return {32'h0, a | b};
         OP_SHR:   return {32'h0, a >> b[4:0]};
         OP_SHRA:  begin t = sa >>> b[4:0]; return {32'h0, t[31:0]}; end
         OP_SHL:   return {32'h0, a << b[4:0]};
         OP_ROR:   begin repeat (int'(b[4:0])) r = {r[0], r[31:1]}; return {32'h0, r}; end
         OP_ROL:   begin repeat (int'(b[4:0])) r = {r[30:0], r[31]}; return {32'h0, r}; end
         OP_NEG:   return {32'h0, 32'h0 - b};
         OP_NOT:   return {32'h0, ~b};
         default:  return 64'h0;
      endcase
   endfunction

   // Apply strobes and precompute the model's post-edge state.
   task automatic drive(input logic [NUM_SRC-1:0] i, input logic [NUM_SRC-1:0] o,
                        input logic [NUM_OPS-1:0] op, input logic y_ld,
                        input logic mux, input logic [31:0] d);
      logic [31:0] b;
      logic [63:0] c;
      in_v = i; out_v = o; op_v = op; yin = y_ld; md_mux = mux; md = d;
      b = ref_bus(o);
      c = ref_alu(m_y, b, op);
      for (int k = 0; k < NUM_SRC; k++) begin
         nx_reg[k] = m_reg[k];
         if (i[k]) begin
            if (k == SRC_ZHI)      nx_reg[k] = c[63:32];
            else if (k == SRC_ZLO) nx_reg[k] = c[31:0];
            else if (k == SRC_MDR) nx_reg[k] = mux ? d : b;
            else                   nx_reg[k] = b;
         end
      end
      nx_y = y_ld ? b : m_y;
      #1;
   endtask

   task automatic commit();
      @(posedge clock);
      #1;
      for (int k = 0; k < NUM_SRC; k++) m_reg[k] = nx_reg[k];
      m_y = nx_y;
      in_v = '0; out_v = '0; op_v = '0; yin = 1'b0; md_mux = 1'b0;
   endtask

   task automatic step(input logic [NUM_SRC-1:0] i, input logic [NUM_SRC-1:0] o,
                       input logic [NUM_OPS-1:0] op, input logic y_ld,
                       input logic mux, input logic [31:0] d);
      drive(i, o, op, y_ld, mux, d);
      commit();
   endtask

   task automatic peek(input int src);
      drive('0, sel(src), '0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic load_mdr(input logic [31:0] d);
      step(sel(SRC_MDR), '0, '0, 1'b0, 1'b1, d);
   endtask

   task automatic load_reg(input int k, input logic [31:0] d);
      load_mdr(d);
      step(sel(k), sel(SRC_MDR), '0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic load_y(input logic [31:0] d);
      load_mdr(d);
      step('0, sel(SRC_MDR), '0, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic model_clear();
      for (int k = 0; k < NUM_SRC; k++) m_reg[k] = 32'h0;
      m_y = 32'h0;
   endtask

   task automatic test_reset();
      load_reg(SRC_PC, 32'hDEADBEEF);
      load_reg(7, 32'h0BADF00D);
      load_y(32'hA5A5A5A5);
      step(sel(SRC_ZHI) | sel(SRC_ZLO), sel(7), opb(OP_MUL), 1'b0, 1'b0, 32'h0);
      @(posedge clock);
      #3 clear = 1'b0;
      model_clear();
      #1;
      for (int k = 0; k < NUM_SRC; k++) begin
         out_v = sel(k);
         #1;
         checks++;
         if (dut.bus !== 32'h0)
            $display("FAIL reset_src%0d: got %h expected %h", k, dut.bus, 32'h0);
         if (dut.bus !== 32'h0) errors++;
      end
      out_v = '0;
      @(posedge clock);
      #1 clear = 1'b1;
      step(sel(SRC_ZLO), '0, opb(OP_ADD), 1'b0, 1'b0, 32'h0);
      peek(SRC_ZLO);
      checks++;
      if (dut.bus !== 32'h0) begin
         errors++;
         $display("FAIL reset_y_cleared: got %h expected %h", dut.bus, 32'h0);
      end
      load_reg(4, 32'h00001234);
      peek(4);
      checks++;
      if (dut.bus !== 32'h00001234) begin
         errors++;
         $display("FAIL reset_first_load: got %h expected %h", dut.bus, 32'h00001234);
      end
   endtask

   task automatic test_load_path();
      load_reg(2, 32'h00000012);
      load_reg(3, 32'hFFFFFFF2);
      peek(2);
      checks++;
      if (dut.bus !== 32'h00000012) begin
         errors++;
         $display("FAIL load_r2: got %h expected %h", dut.bus, 32'h00000012);
      end
      peek(3);
      checks++;
      if (dut.bus !== 32'hFFFFFFF2) begin
         errors++;
         $display("FAIL load_r3: got %h expected %h", dut.bus, 32'hFFFFFFF2);
      end
   endtask

   task automatic test_sub_sequence();
      step(sel(SRC_ZLO), sel(SRC_PC), opb(OP_INCPC), 1'b0, 1'b0, 32'h0);
      step(sel(SRC_PC) | sel(SRC_MDR), sel(SRC_ZLO), '0, 1'b0, 1'b1, 32'h20918000);
      step(sel(SRC_IR), sel(SRC_MDR), '0, 1'b0, 1'b0, 32'h0);
      step('0, sel(2), '0, 1'b1, 1'b0, 32'h0);
      step(sel(SRC_ZLO), sel(3), opb(OP_SUB), 1'b0, 1'b0, 32'h0);
      step(sel(1), sel(SRC_ZLO), '0, 1'b0, 1'b0, 32'h0);
      peek(SRC_PC);
      checks++;
      if (dut.bus !== 32'h00000001) begin
         errors++;
         $display("FAIL sub_seq_pc: got %h expected %h", dut.bus, 32'h00000001);
      end
      peek(SRC_IR);
      checks++;
      if (dut.bus !== 32'h20918000) begin
         errors++;
         $display("FAIL sub_seq_ir: got %h expected %h", dut.bus, 32'h20918000);
      end
      peek(1);
      checks++;
      if (dut.bus !== 32'h00000020) begin
         errors++;
         $display("FAIL sub_seq_r1: got %h expected %h", dut.bus, 32'h00000020);
      end
   endtask

   task automatic test_mul_div();
      logic [31:0] exp_hi [3];
      logic [31:0] exp_lo [3];
      exp_hi[0] = 32'hFFFFFFFF; exp_lo[0] = 32'hFFFFFFD6;
      exp_hi[1] = 32'hFFFFFFFF; exp_lo[1] = 32'hFFFFFFFD;
      exp_hi[2] = 32'h00000000; exp_lo[2] = 32'h00000000;
      for (int t = 0; t < 3; t++) begin
         if (t == 0) begin
            load_y(32'hFFFFFFFA);
            load_mdr(32'd7);
            step(sel(SRC_ZHI) | sel(SRC_ZLO), sel(SRC_MDR), opb(OP_MUL), 1'b0, 1'b0, 32'h0);
         end else if (t == 1) begin
            load_y(32'hFFFFFFF9);
            load_mdr(32'd2);
            step(sel(SRC_ZHI) | sel(SRC_ZLO), sel(SRC_MDR), opb(OP_DIV), 1'b0, 1'b0, 32'h0);
         end else begin
            step(sel(SRC_ZHI) | sel(SRC_ZLO), '0, opb(OP_DIV), 1'b0, 1'b0, 32'h0);
         end
         peek(SRC_ZHI);
         checks++;
         if (dut.bus !== exp_hi[t]) begin
            errors++;
            $display("FAIL muldiv%0d_zhigh: got %h expected %h", t, dut.bus, exp_hi[t]);
         end
         peek(SRC_ZLO);
         checks++;
         if (dut.bus !== exp_lo[t]) begin
            errors++;
            $display("FAIL muldiv%0d_zlow: got %h expected %h", t, dut.bus, exp_lo[t]);
         end
      end
   endtask

   task automatic test_shift_logic();
      int          t_op  [8];
      logic [31:0] t_exp [8];
      logic [NUM_SRC-1:0] src;
      t_op[0] = OP_SHR;  t_exp[0] = 32'h40000000;
      t_op[1] = OP_SHRA; t_exp[1] = 32'hC0000000;
      t_op[2] = OP_SHL;  t_exp[2] = 32'h00000002;
      t_op[3] = OP_ROR;  t_exp[3] = 32'hC0000000;
      t_op[4] = OP_ROL;  t_exp[4] = 32'h00000003;
      t_op[5] = OP_NEG;  t_exp[5] = 32'hFFFFFFFF;
      t_op[6] = OP_NOT;  t_exp[6] = 32'hFFFFFFFF;
      t_op[7] = OP_ADD;  t_exp[7] = 32'h80000002;
      load_y(32'h80000001);
      load_mdr(32'h00000001);
      for (int t = 0; t < 8; t++) begin
         src = (t == 6) ? '0 : sel(SRC_MDR);
         step(sel(SRC_ZHI) | sel(SRC_ZLO), src,
              (t == 7) ? (opb(OP_ADD) | opb(OP_SHL)) : opb(t_op[t]), 1'b0, 1'b0, 32'h0);
         peek(SRC_ZLO);
         checks++;
         if (dut.bus !== t_exp[t]) begin
            errors++;
            $display("FAIL shiftlogic_op%0d_zlow: got %h expected %h", t_op[t], dut.bus, t_exp[t]);
         end
         peek(SRC_ZHI);
         checks++;
         if (dut.bus !== 32'h0) begin
            errors++;
            $display("FAIL shiftlogic_op%0d_zhigh: got %h expected %h", t_op[t], dut.bus, 32'h0);
         end
      end
   endtask

   task automatic test_bus_priority();
      load_reg(1, 32'h11111111);
      load_reg(5, 32'h55555555);
      load_reg(SRC_HI, 32'h0000ABCD);
      load_reg(SRC_IR, 32'h12340000);
      drive('0, sel(1) | sel(5), '0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (dut.bus !== 32'h11111111) begin
         errors++;
         $display("FAIL prio_r1_r5: got %h expected %h", dut.bus, 32'h11111111);
      end
      drive('0, sel(SRC_IR) | sel(SRC_HI), '0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (dut.bus !== 32'h0000ABCD) begin
         errors++;
         $display("FAIL prio_hi_ir: got %h expected %h", dut.bus, 32'h0000ABCD);
      end
      drive('0, '0, '0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (dut.bus !== 32'h0) begin
         errors++;
         $display("FAIL prio_idle_bus: got %h expected %h", dut.bus, 32'h0);
      end
      load_y(32'h77777777);
      step('0, '0, '0, 1'b1, 1'b0, 32'h0);
      step(sel(SRC_ZLO), sel(1), opb(OP_ADD), 1'b0, 1'b0, 32'h0);
      peek(SRC_ZLO);
      checks++;
      if (dut.bus !== 32'h11111111) begin
         errors++;
         $display("FAIL prio_yin_idle: got %h expected %h", dut.bus, 32'h11111111);
      end
   endtask

   task automatic test_random();
      logic [NUM_SRC-1:0] i, o;
      logic [NUM_OPS-1:0] op;
      logic [31:0]        eb;
      for (int n = 0; n < 500; n++) begin
         o = '0;
         repeat ($urandom_range(0, 2)) o[$urandom_range(0, NUM_SRC - 1)] = 1'b1;
         i = '0;
         repeat ($urandom_range(0, 3)) i[$urandom_range(0, NUM_SRC - 1)] = 1'b1;
         if ($urandom_range(0, 3) == 0) i[SRC_MDR] = 1'b1;
         op = '0;
         repeat ($urandom_range(0, 2)) op[$urandom_range(0, NUM_OPS - 1)] = 1'b1;
         eb = ref_bus(o);
         drive(i, o, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
         checks++;
         if (dut.bus !== eb) begin
            errors++;
            $display("FAIL random_bus_cycle%0d: got %h expected %h", n, dut.bus, eb);
         end
         commit();
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         peek(k);
         checks++;
         if (dut.bus !== m_reg[k]) begin
            errors++;
            $display("FAIL random_final_src%0d: got %h expected %h", k, dut.bus, m_reg[k]);
         end
      end
   endtask

   initial begin
      clear = 1'b0;
      in_v = '0; out_v = '0; op_v = '0; yin = 1'b0; md_mux = 1'b0; md = 32'h0;
      model_clear();
      repeat (3) @(posedge clock);
      #1 clear = 1'b1;
      test_reset();
      test_load_path();
      test_sub_sequence();
      test_mul_div();
      test_shift_logic();
      test_bus_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
